// File: rtl/matmul_pkg.sv
// Shared types and helpers for the parametrised sequential matrix multiplier.
// Widths are sized for the largest legal configuration (VAR_WIDTH=16, M_SIZE=8).
package matmul_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_STORE = 2'd2
  } state_e;

  localparam int unsigned MAX_VAR_W = 16;
  localparam int unsigned MAX_ACC_W = 2 * MAX_VAR_W + 3;

  // Truncate to var_w bits, or clamp to all-ones when sat is set and the value overflows.
  function automatic logic [MAX_VAR_W-1:0] reduce_elem(
    input logic [MAX_ACC_W-1:0] acc,
    input int unsigned          var_w,
    input logic                 sat
  );
    logic [MAX_ACC_W-1:0] mask;
    logic [MAX_VAR_W-1:0] low;
    logic                 over;
    mask = ~({MAX_ACC_W{1'b1}} << var_w);
    low  = acc[MAX_VAR_W-1:0] & mask[MAX_VAR_W-1:0];
    over = |(acc & ~mask);
    return (sat && over) ? mask[MAX_VAR_W-1:0] : low;
  endfunction

  // Bit offset of element (r,c) in a row-major packed m x m matrix of w-bit elements.
  function automatic int unsigned elem_lsb(
    input int unsigned r,
    input int unsigned c,
    input int unsigned m,
    input int unsigned w
  );
    return w * (r * m + c);
  endfunction

endpackage

// File: rtl/matmul_mac_lane.sv
// Single multiply-accumulate lane: exact accumulator plus reduction of the final sum.
// elem_o is the reduced value of acc + a*b, valid in the cycle last_i is high.
module matmul_mac_lane
  import matmul_pkg::*;
#(
  parameter int VAR_WIDTH = 4,
  parameter int ACC_WIDTH = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 mac_en_i,
  input  logic                 last_i,
  input  logic                 sat_i,
  input  logic [VAR_WIDTH-1:0] a_i,
  input  logic [VAR_WIDTH-1:0] b_i,
  output logic [VAR_WIDTH-1:0] elem_o
);

  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   sum;
  logic [2*VAR_WIDTH-1:0] prod;
  logic [MAX_ACC_W-1:0]   sum_ext;
  logic [MAX_VAR_W-1:0]   red_full;
  logic                   unused_red;

  always_comb begin
    prod    = a_i * b_i;
    sum     = acc_q + ACC_WIDTH'(prod);
    sum_ext = '0;
    sum_ext[ACC_WIDTH-1:0] = sum;
    red_full = reduce_elem(sum_ext, VAR_WIDTH, sat_i);
  end

  assign elem_o     = red_full[VAR_WIDTH-1:0];
  assign unused_red = ^red_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (mac_en_i) begin
      acc_q <= last_i ? '0 : sum;
    end
  end

endmodule

// File: rtl/matmul_param_unit.sv
// Sequential M_SIZE x M_SIZE unsigned matrix multiplier, one MAC per cycle.
// Handshake: start is accepted only in S_IDLE; busy spans the run; done pulses one cycle with result valid.
module matmul_param_unit
  import matmul_pkg::*;
#(
  parameter int VAR_WIDTH = 4,
  parameter int M_SIZE    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                sat_mode,
  input  logic [VAR_WIDTH*M_SIZE*M_SIZE-1:0]  matrixA,
  input  logic [VAR_WIDTH*M_SIZE*M_SIZE-1:0]  matrixB,
  output logic [VAR_WIDTH*M_SIZE*M_SIZE-1:0]  result,
  output logic                                busy,
  output logic                                done,
  output logic [1:0]                          dbg_state
);

  localparam int ACC_WIDTH = 2 * VAR_WIDTH + $clog2(M_SIZE);
  localparam int MAT_W     = VAR_WIDTH * M_SIZE * M_SIZE;
  localparam int CW        = $clog2(M_SIZE);
  localparam logic [CW-1:0] LAST_IDX = CW'(M_SIZE - 1);

  state_e state_q, state_d;

  logic [CW-1:0]        i_q, j_q, k_q;
  logic [MAT_W-1:0]     a_q, b_q, res_arr_q, result_q;
  logic                 sat_q, busy_q, done_q;
  logic                 k_last, j_last, i_last;
  logic                 mac_en, clear_acc;
  logic [VAR_WIDTH-1:0] a_elem, b_elem, lane_elem;

  assign k_last = (k_q == LAST_IDX);
  assign j_last = (j_q == LAST_IDX);
  assign i_last = (i_q == LAST_IDX);

  assign a_elem = a_q[elem_lsb(int'(i_q), int'(k_q), M_SIZE, VAR_WIDTH) +: VAR_WIDTH];
  assign b_elem = b_q[elem_lsb(int'(k_q), int'(j_q), M_SIZE, VAR_WIDTH) +: VAR_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (k_last && j_last && i_last) state_d = S_STORE;
      S_STORE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mac_en    = 1'b0;
    clear_acc = 1'b0;
    case (state_q)
      S_IDLE:  clear_acc = start;
      S_CALC:  mac_en    = 1'b1;
      default: ;
    endcase
  end

  matmul_mac_lane #(
    .VAR_WIDTH (VAR_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_lane (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clear_i  (clear_acc),
    .mac_en_i (mac_en),
    .last_i   (k_last),
    .sat_i    (sat_q),
    .a_i      (a_elem),
    .b_i      (b_elem),
    .elem_o   (lane_elem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sat_q     <= 1'b0;
      res_arr_q <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q    <= matrixA;
            b_q    <= matrixB;
            sat_q  <= sat_mode;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            busy_q <= 1'b1;
          end
        end
        S_CALC: begin
          if (k_last) begin
            res_arr_q[elem_lsb(int'(i_q), int'(j_q), M_SIZE, VAR_WIDTH) +: VAR_WIDTH] <= lane_elem;
            k_q <= '0;
            if (j_last) begin
              j_q <= '0;
              i_q <= i_last ? '0 : i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_STORE: begin
          result_q <= res_arr_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matmul_param_unit.sv
// Directed bench for matmul_param_unit: a 4x4/4-bit instance and a 2x2/8-bit instance.
module tb_matmul_param_unit;

  logic          clk;
  logic          rst4, start4, sat4;
  logic [63:0]   a4, b4, res4;
  logic          busy4, done4;
  logic [1:0]    st4;
  logic          rst2, start2, sat2;
  logic [31:0]   a2, b2, res2;
  logic          busy2, done2;
  logic [1:0]    st2;

  int n_cmp;
  int n_fail;

  logic [63:0] ident4, seq4, ones4, fif4, fours4, allf4;

  matmul_param_unit #(.VAR_WIDTH(4), .M_SIZE(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .sat_mode(sat4),
    .matrixA(a4), .matrixB(b4), .result(res4),
    .busy(busy4), .done(done4), .dbg_state(st4)
  );

  matmul_param_unit #(.VAR_WIDTH(8), .M_SIZE(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .sat_mode(sat2),
    .matrixA(a2), .matrixB(b2), .result(res2),
    .busy(busy2), .done(done2), .dbg_state(st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a start on the 4x4 unit and count edges to done; busy_low counts cycles busy dropped early.
  task automatic run4(input logic [63:0] a, input logic [63:0] b, input logic s,
                      output int lat, output int busy_low);
    a4 = a; b4 = b; sat4 = s; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0; busy_low = 0;
    if (!busy4) busy_low++;
    while (lat < 200) begin
      tick();
      lat++;
      if (done4) break;
      if (!busy4) busy_low++;
    end
  endtask

  task automatic wait2(output int lat);
    lat = 0;
    while (lat < 50) begin
      tick();
      lat++;
      if (done2) break;
    end
  endtask

  task automatic test_reset();
    rst4 = 1'b0; rst2 = 1'b0;
    start4 = 0; sat4 = 0; a4 = '0; b4 = '0;
    start2 = 0; sat2 = 0; a2 = '0; b2 = '0;
    tick(); tick();
    n_cmp++; if (res4 !== 64'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", res4); end
    n_cmp++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin n_fail++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy4, done4); end
    n_cmp++; if (st4 !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", st4); end
    rst4 = 1'b1; rst2 = 1'b1;
    tick();
  endtask

  task automatic test_identity();
    int lat, bl;
    run4(ident4, seq4, 1'b0, lat, bl);
    n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL ident_latency got %0d want 65", lat); end
    n_cmp++; if (bl !== 0) begin n_fail++; $display("FAIL ident_busy got %0d low cycles want 0", bl); end
    n_cmp++; if (res4 !== seq4) begin n_fail++; $display("FAIL ident_result got %h want %h", res4, seq4); end
    n_cmp++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL ident_busy_at_done got %b want 0", busy4); end
    tick();
    n_cmp++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b want 0", done4); end
  endtask

  task automatic test_ones();
    int lat, bl;
    for (int m = 0; m < 2; m++) begin
      run4(ones4, ones4, m[0], lat, bl);
      n_cmp++; if (res4 !== fours4) begin n_fail++; $display("FAIL ones_mode%0d got %h want %h", m, res4, fours4); end
    end
  endtask

  task automatic test_fifteens();
    int lat, bl;
    run4(fif4, fif4, 1'b0, lat, bl);
    n_cmp++; if (res4 !== fours4) begin n_fail++; $display("FAIL f15_trunc got %h want %h", res4, fours4); end
    run4(fif4, fif4, 1'b1, lat, bl);
    n_cmp++; if (res4 !== allf4) begin n_fail++; $display("FAIL f15_sat got %h want %h", res4, allf4); end
  endtask

  task automatic test_latch();
    int dones;
    a4 = ident4; b4 = seq4; sat4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0; a4 = fif4; b4 = fif4; sat4 = 1'b1;
    dones = 0;
    for (int c = 0; c < 80; c++) begin
      start4 = (c == 20);
      tick();
      if (done4) dones++;
    end
    start4 = 1'b0;
    n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL latch_dones got %0d want 1", dones); end
    n_cmp++; if (res4 !== seq4) begin n_fail++; $display("FAIL latch_result got %h want %h", res4, seq4); end
  endtask

  task automatic test_abort();
    int dones, lat, bl;
    a4 = ones4; b4 = ones4; sat4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 0; c < 30; c++) tick();
    rst4 = 1'b0;
    #1;
    n_cmp++; if (res4 !== 64'd0) begin n_fail++; $display("FAIL abort_result got %h want 0", res4); end
    n_cmp++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin n_fail++; $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy4, done4); end
    tick(); tick();
    rst4 = 1'b1;
    dones = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (done4) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL abort_nodone got %0d want 0", dones); end
    run4(ident4, seq4, 1'b0, lat, bl);
    n_cmp++; if (res4 !== seq4 || lat !== 65) begin n_fail++; $display("FAIL abort_rerun got %h lat %0d want %h lat 65", res4, lat, seq4); end
  endtask

  task automatic test_back_to_back();
    int lat;
    a2 = 32'h04030201; b2 = 32'h08070605; sat2 = 1'b0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    wait2(lat);
    n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL m2_latency got %0d want 9", lat); end
    n_cmp++; if (res2 !== 32'h322B1613) begin n_fail++; $display("FAIL m2_result got %h want 322b1613", res2); end
    a2 = 32'h01000001; b2 = 32'h0A141E28; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n_cmp++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy=%b want 1", busy2); end
    wait2(lat);
    n_cmp++; if (lat !== 9 || res2 !== 32'h0A141E28) begin n_fail++; $display("FAIL b2b_result got %h lat %0d want 0a141e28 lat 9", res2, lat); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    ident4 = '0; seq4 = '0; ones4 = '0; fif4 = '0; fours4 = '0; allf4 = '0;
    for (int n = 0; n < 16; n++) begin
      seq4[n*4 +: 4]   = 4'(n);
      ones4[n*4 +: 4]  = 4'd1;
      fif4[n*4 +: 4]   = 4'd15;
      fours4[n*4 +: 4] = 4'd4;
      allf4[n*4 +: 4]  = 4'd15;
    end
    for (int r = 0; r < 4; r++) ident4[(r*4 + r)*4 +: 4] = 4'd1;
    test_reset();
    test_identity();
    test_ones();
    test_fifteens();
    test_latch();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_param_unit.md
Name: matmul_param_unit

Overview:
- Parametrised successor to the fixed 4x4, 4-bit sequential matrix multiplier in the TensorFlowE datapath.
- Computes result = A x B for M_SIZE x M_SIZE unsigned matrices of VAR_WIDTH-bit elements, one multiply-accumulate per cycle.
- New over the previous generation: operands latched at start, start/busy/done handshake, selectable truncate or saturate output, full-width accumulator.

Parameters:
- VAR_WIDTH, 4, element width in bits (legal 2..16).
- M_SIZE, 4, matrix dimension (legal 2..8).
- ACC_WIDTH, 2*VAR_WIDTH+$clog2(M_SIZE), accumulator width; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in S_IDLE.
- sat_mode  in  1  0 = truncate to low VAR_WIDTH bits, 1 = saturate to 2^VAR_WIDTH-1; sampled with start.
- matrixA  in  VAR_WIDTH*M_SIZE*M_SIZE  packed A; element (r,c) at bits VAR_WIDTH*(r*M_SIZE+c).
- matrixB  in  same width  packed B, same packing.
- result  out  same width  packed A x B, same packing.
- busy  out  1  high from the edge that accepts start until the edge that asserts done.
- done  out  1  single-cycle pulse, result valid.

Behaviour:
- Reset (rst low, asynchronous): state=S_IDLE; i, j, k, accumulator, latched operands, internal result array, result, busy, done, and latched sat_mode all 0.
- S_IDLE: done<=0. If start, latch matrixA, matrixB and sat_mode; clear i, j, k and accumulator; busy<=1; go to S_CALC. Inputs may change freely after the accepting edge.
- S_CALC, one edge per MAC:
  - k < M_SIZE-1: accumulator <= accumulator + A[i][k]*B[k][j]; k<=k+1.
  - k == M_SIZE-1: element (i,j) <= reduce(accumulator + A[i][k]*B[k][j]); accumulator<=0; k<=0; advance j; on j wrap advance i.
  - After element (M-1,M-1) is written: i=j=0, go to S_STORE.
- S_STORE: result <= packed internal array; done<=1; busy<=0; go to S_IDLE.
- Latency: from the start-accepting edge to the edge that raises done is M_SIZE^3+1 edges (65 for M=4). done is high for exactly one cycle.
- result holds its value until the next S_STORE. Intermediate elements are never visible on result.
- start while busy is ignored; no queueing.
- start high in the cycle done is high is accepted, giving back-to-back operation.
- Held-high start restarts continuously.
- reduce(): the accumulator is exact (no overflow at ACC_WIDTH). sat_mode=0 takes the low VAR_WIDTH bits. sat_mode=1 outputs all-ones if any bit above VAR_WIDTH-1 is set, else the value.
- Reset mid-operation aborts immediately; result returns to 0 and no done is issued.

Decomposition:
- Package matmul_pkg: state enum (S_IDLE, S_CALC, S_STORE), function reduce_elem(acc, sat) parametrised by widths, packing index helper.
- One sub-module, matmul_mac_lane: holds the accumulator and performs the multiply-add plus reduce. The top keeps the FSM, counters, operand latches and result array.

Test Plan:
- M=4, W=4; A=identity, B with elements 0..15 in packing order; sat_mode=0 -> result==matrixB, done at 65 edges after start, busy high in between.
- A and B all 1s -> every element 4 in both modes.
- A and B all 15s -> accumulator 900 (0x384). sat_mode=0 gives every element 4; sat_mode=1 gives every element 15.
- Change matrixA/B/sat_mode the cycle after start and pulse start mid-run -> result reflects the latched values; exactly one done.
- Deassert rst at cycle 30 of a run -> all outputs 0 immediately, no done; a fresh start then completes correctly.
- Second config M=2, W=8; A={{1,2},{3,4}}, B={{5,6},{7,8}} -> {{19,22},{43,50}}, done after 9 edges; a back-to-back start on the done cycle is accepted.
